mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between an execute stage and a
// single-port data memory with a valid/ready request channel and a valid-only
// read response channel.
//
// Optional build macro: MEM_ACCESS_TIMEOUT_EN
//   When defined, an access that waits TIMEOUT_CYCLES cycles in REQ/WAIT_RSP
//   is aborted: DONE is entered with o_mem_err=1 and o_wb_data=0.
//   When undefined, the unit waits forever and o_mem_err is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepting a new instruction on i_op_valid
// REQ      | request presented, waiting for i_mem_req_ready
// WAIT_RSP | read accepted, waiting for i_mem_rsp_valid
// DONE     | one-cycle writeback pulse, returns to IDLE

module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_op_valid,
    input  logic              i_ctrl_mem_r,
    input  logic              i_ctrl_mem_w,
    input  logic              i_ctrl_mem_to_reg,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic              o_mem_req_we,
    output logic [ADDR_W-1:0] o_mem_req_addr,
    output logic [DATA_W-1:0] o_mem_req_wdata,
    input  logic              i_mem_rsp_valid,
    input  logic [DATA_W-1:0] i_mem_rsp_rdata,
    output logic              o_wb_valid,
    output logic [DATA_W-1:0] o_wb_data,
    output logic              o_stall,
    output logic              o_mem_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] w_wb_data_next;
    logic              r_is_write;
    logic              r_mem_to_reg;
    logic              r_err;
    logic              w_err_next;
    logic              w_timeout;
    logic              w_busy;

    assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT_RSP);

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;

    // Wait-cycle counter: cleared when an access enters REQ, counts every REQ/WAIT_RSP cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (w_busy) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // The cycle in which the count would reach TIMEOUT_CYCLES is the last wait cycle.
    assign w_timeout = w_busy && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_timeout    = 1'b0;
`endif

    // State register and per-instruction capture; reset abandons any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_alu        <= '0;
            r_wdata      <= '0;
            r_wb_data    <= '0;
            r_is_write   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_wb_data <= w_wb_data_next;
            r_err     <= w_err_next;
            if (r_state == S_IDLE && i_op_valid) begin
                r_alu        <= i_alu_result;
                r_wdata      <= i_store_data;
                r_mem_to_reg <= i_ctrl_mem_to_reg;
                r_is_write   <= i_ctrl_mem_w;
            end
        end
    end

    // Next-state logic; writeback data is resolved on the transition into DONE
    // so it is stable during DONE and simply holds afterwards.
    always_comb begin
        w_state_next   = r_state;
        w_wb_data_next = r_wb_data;
        w_err_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_op_valid) begin
                    if (i_ctrl_mem_w || i_ctrl_mem_r) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next   = S_DONE;
                        w_wb_data_next = i_alu_result;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_req_ready) begin
                    if (r_is_write) begin
                        w_state_next   = S_DONE;
                        w_wb_data_next = r_alu;
                    end else begin
                        w_state_next = S_WAIT_RSP;
                    end
                end else if (w_timeout) begin
                    w_state_next   = S_DONE;
                    w_wb_data_next = '0;
                    w_err_next     = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                if (i_mem_rsp_valid) begin
                    w_state_next   = S_DONE;
                    w_wb_data_next = r_mem_to_reg ? i_mem_rsp_rdata : r_alu;
                end else if (w_timeout) begin
                    w_state_next   = S_DONE;
                    w_wb_data_next = '0;
                    w_err_next     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_mem_req_we    = r_is_write;
    assign o_mem_req_addr  = r_alu[ADDR_W-1:0];
    assign o_mem_req_wdata = r_wdata;
    assign o_wb_valid      = (r_state == S_DONE);
    assign o_wb_data       = r_wb_data;
    assign o_mem_err       = r_err;
    assign o_stall         = (r_state == S_IDLE && i_op_valid && (i_ctrl_mem_r || i_ctrl_mem_w))
                             || w_busy;

endmodule
